// File: rtl/ctrl_pkg.sv
// Shared constants and types for the single-cycle control unit.
// This package holds the opcodes, ALU codes, FSM states, fault codes and the control bundle.
package ctrl_pkg;

  localparam logic [5:0] OP_ADDI = 6'h20;
  localparam logic [5:0] OP_LW   = 6'h21;
  localparam logic [5:0] OP_SW   = 6'h22;
  localparam logic [5:0] OP_BEQ  = 6'h23;
  localparam logic [5:0] OP_BNE  = 6'h24;
  localparam logic [5:0] OP_CALL = 6'h25;
  localparam logic [5:0] OP_RET  = 6'h26;
  localparam logic [5:0] OP_HALT = 6'h3F;

  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_OVERFLOW  = 2'b10;
  localparam logic [1:0] FAULT_UNDERFLOW = 2'b11;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem2reg;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       pc_src;
    logic [4:0] alu_op;
    logic       push;
    logic       pop;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decode. It produces the RUN-state control bundle,
// and it flags halt and fault requests for the owning FSM.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int ILLEGAL_TRAP = 1
) (
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       stack_valid,
  output ctrl_t      ctrl,
  output logic       halt_req,
  output logic       fault_req,
  output logic [1:0] fault_code
);

  always_comb begin
    ctrl       = '0;
    halt_req   = 1'b0;
    fault_req  = 1'b0;
    fault_code = FAULT_NONE;
    if (!op[5]) begin
      ctrl.reg_dst   = 1'b1;
      ctrl.reg_write = 1'b1;
      ctrl.alu_op    = op[4:0];
    end else begin
      case (op)
        OP_ADDI: begin
          ctrl.alu_src   = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.alu_op    = ALU_ADD;
        end
        OP_LW: begin
          ctrl.alu_src   = 1'b1;
          ctrl.mem2reg   = 1'b1;
          ctrl.mem_read  = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.alu_op    = ALU_ADD;
        end
        OP_SW: begin
          ctrl.alu_src   = 1'b1;
          ctrl.mem_write = 1'b1;
          ctrl.alu_op    = ALU_ADD;
        end
        OP_BEQ: begin
          ctrl.alu_op = ALU_SUB;
          ctrl.pc_src = zero;
        end
        OP_BNE: begin
          ctrl.alu_op = ALU_SUB;
          ctrl.pc_src = ~zero;
        end
        // The return register has one entry, so a second CALL overflows it.
        OP_CALL: begin
          if (stack_valid) begin
            fault_req  = 1'b1;
            fault_code = FAULT_OVERFLOW;
          end else begin
            ctrl.push   = 1'b1;
            ctrl.pc_src = 1'b1;
          end
        end
        OP_RET: begin
          if (!stack_valid) begin
            fault_req  = 1'b1;
            fault_code = FAULT_UNDERFLOW;
          end else begin
            ctrl.pop = 1'b1;
          end
        end
        OP_HALT: halt_req = 1'b1;
        default: begin
          if (ILLEGAL_TRAP != 0) begin
            fault_req  = 1'b1;
            fault_code = FAULT_ILLEGAL;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/control_fsm.sv
// RUN/HALT/FAULT control FSM. It gates the decoded controls and owns the
// state, return-register valid, fault code and retired-instruction counter.
module control_fsm
  import ctrl_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int ILLEGAL_TRAP = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic             zero,
  output logic             RegDst,
  output logic             ALUSrc,
  output logic             Mem2Reg,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             PCSrc,
  output logic [4:0]       ALUOp,
  output logic             push,
  output logic             pop,
  output logic             halted,
  output logic [1:0]       fault,
  output logic             stack_valid,
  output logic [CNT_W-1:0] instret
);

  state_t           state_reg;
  logic             stack_valid_reg;
  logic [1:0]       fault_reg;
  logic [CNT_W-1:0] instret_reg;

  ctrl_t      dec_ctrl;
  ctrl_t      ctrl_out;
  logic       halt_req;
  logic       fault_req;
  logic [1:0] fault_code;

  ctrl_decode #(
    .ILLEGAL_TRAP(ILLEGAL_TRAP)
  ) u_decode (
    .op         (op),
    .zero       (zero),
    .stack_valid(stack_valid_reg),
    .ctrl       (dec_ctrl),
    .halt_req   (halt_req),
    .fault_req  (fault_req),
    .fault_code (fault_code)
  );

  // Faulting opcodes already decode to an all-zero bundle; this handles reset and the idle states.
  assign ctrl_out = (state_reg == ST_RUN && !reset) ? dec_ctrl : '0;

  assign RegDst   = ctrl_out.reg_dst;
  assign ALUSrc   = ctrl_out.alu_src;
  assign Mem2Reg  = ctrl_out.mem2reg;
  assign MemRead  = ctrl_out.mem_read;
  assign MemWrite = ctrl_out.mem_write;
  assign RegWrite = ctrl_out.reg_write;
  assign PCSrc    = ctrl_out.pc_src;
  assign ALUOp    = ctrl_out.alu_op;
  assign push     = ctrl_out.push;
  assign pop      = ctrl_out.pop;

  assign halted      = (state_reg == ST_HALT);
  assign fault       = fault_reg;
  assign stack_valid = stack_valid_reg;
  assign instret     = instret_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_RUN;
      stack_valid_reg <= 1'b0;
      fault_reg       <= FAULT_NONE;
      instret_reg     <= '0;
    end else if (state_reg == ST_RUN) begin
      if (halt_req) begin
        state_reg <= ST_HALT;
      end else if (fault_req) begin
        state_reg <= ST_FAULT;
        fault_reg <= fault_code;
      end else begin
        if (instret_reg != '1) begin
          instret_reg <= instret_reg + CNT_W'(1);
        end
        if (dec_ctrl.push) begin
          stack_valid_reg <= 1'b1;
        end else if (dec_ctrl.pop) begin
          stack_valid_reg <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_control_fsm.sv
// Testbench for control_fsm. It runs directed scenarios and then random opcodes against
// two instances (trapping with a 32-bit counter, non-trapping with a 4-bit counter).
module tb_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       zero;

  logic [1:0] reg_dst, alu_src, mem2reg, mem_read, mem_write, reg_write, pc_src;
  logic [1:0] push, pop, halted, stack_valid;
  logic [4:0] alu_op [2];
  logic [1:0] fault_v [2];
  logic [31:0] instret_a;
  logic [3:0]  instret_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state, one slot per instance
  bit          m_halt  [2];
  bit          m_flt   [2];
  logic [1:0]  m_code  [2];
  bit          m_sv    [2];
  longint      m_cnt   [2];
  longint      m_max   [2] = '{64'hFFFF_FFFF, 64'd15};
  bit          m_trap  [2] = '{1'b1, 1'b0};

  always #5 clk = ~clk;

  control_fsm #(.CNT_W(32), .ILLEGAL_TRAP(1)) dut_a (
    .clk(clk), .reset(reset), .op(op), .zero(zero),
    .RegDst(reg_dst[0]), .ALUSrc(alu_src[0]), .Mem2Reg(mem2reg[0]), .MemRead(mem_read[0]),
    .MemWrite(mem_write[0]), .RegWrite(reg_write[0]), .PCSrc(pc_src[0]), .ALUOp(alu_op[0]),
    .push(push[0]), .pop(pop[0]), .halted(halted[0]), .fault(fault_v[0]),
    .stack_valid(stack_valid[0]), .instret(instret_a)
  );

  control_fsm #(.CNT_W(4), .ILLEGAL_TRAP(0)) dut_b (
    .clk(clk), .reset(reset), .op(op), .zero(zero),
    .RegDst(reg_dst[1]), .ALUSrc(alu_src[1]), .Mem2Reg(mem2reg[1]), .MemRead(mem_read[1]),
    .MemWrite(mem_write[1]), .RegWrite(reg_write[1]), .PCSrc(pc_src[1]), .ALUOp(alu_op[1]),
    .push(push[1]), .pop(pop[1]), .halted(halted[1]), .fault(fault_v[1]),
    .stack_valid(stack_valid[1]), .instret(instret_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_listed(input logic [5:0] o);
    return (o == 6'h20 || o == 6'h21 || o == 6'h22 || o == 6'h23 ||
            o == 6'h24 || o == 6'h25 || o == 6'h26 || o == 6'h3F);
  endfunction

  // Expected {RegDst,ALUSrc,Mem2Reg,MemRead,MemWrite,RegWrite,PCSrc,ALUOp,push,pop}
  function automatic logic [13:0] exp_ctrl(input int i, input logic [5:0] o, input logic z, input logic r);
    logic rd = 0, as = 0, m2r = 0, mr = 0, mw = 0, rw = 0, pcs = 0, pu = 0, po = 0;
    logic [4:0] alu = 0;
    if (!r && !m_halt[i] && !m_flt[i]) begin
      if (o < 6'h20) begin rd = 1; rw = 1; alu = o[4:0]; end
      else if (o == 6'h20) begin as = 1; rw = 1; end
      else if (o == 6'h21) begin as = 1; m2r = 1; mr = 1; rw = 1; end
      else if (o == 6'h22) begin as = 1; mw = 1; end
      else if (o == 6'h23) begin alu = 5'd1; pcs = z; end
      else if (o == 6'h24) begin alu = 5'd1; pcs = !z; end
      else if (o == 6'h25 && !m_sv[i]) begin pu = 1; pcs = 1; end
      else if (o == 6'h26 && m_sv[i]) po = 1;
    end
    return {rd, as, m2r, mr, mw, rw, pcs, alu, pu, po};
  endfunction

  task automatic model_advance(input int i, input logic [5:0] o, input logic r);
    if (r) begin
      m_halt[i] = 0; m_flt[i] = 0; m_code[i] = 2'b00; m_sv[i] = 0; m_cnt[i] = 0;
    end else if (!m_halt[i] && !m_flt[i]) begin
      if (o == 6'h3F) m_halt[i] = 1;
      else if (o == 6'h25 && m_sv[i]) begin m_flt[i] = 1; m_code[i] = 2'b10; end
      else if (o == 6'h26 && !m_sv[i]) begin m_flt[i] = 1; m_code[i] = 2'b11; end
      else if (o[5] && !is_listed(o) && m_trap[i]) begin m_flt[i] = 1; m_code[i] = 2'b01; end
      else begin
        if (m_cnt[i] < m_max[i]) m_cnt[i]++;
        if (o == 6'h25) m_sv[i] = 1;
        if (o == 6'h26) m_sv[i] = 0;
      end
    end
  endtask

  task automatic step(input logic [5:0] o, input logic z, input logic r);
    @(negedge clk);
    op = o; zero = z; reset = r;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("ctrl%0d op=%02h", i, o),
            {reg_dst[i], alu_src[i], mem2reg[i], mem_read[i], mem_write[i], reg_write[i],
             pc_src[i], alu_op[i], push[i], pop[i]}, exp_ctrl(i, o, z, r));
      check($sformatf("halted%0d", i), halted[i], m_halt[i]);
      check($sformatf("fault%0d", i), fault_v[i], m_flt[i] ? m_code[i] : 2'b00);
      check($sformatf("stack_valid%0d", i), stack_valid[i], m_sv[i]);
      check($sformatf("instret%0d", i), (i == 0) ? 64'(instret_a) : 64'(instret_b), m_cnt[i]);
    end
    for (int i = 0; i < 2; i++) model_advance(i, o, r);
    $display("txn op=%02h zero=%0b reset=%0b instret_a=%0d instret_b=%0d", o, z, r, instret_a, instret_b);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; op = 6'h00; zero = 1'b0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 2; i++) model_advance(i, 6'h00, 1'b1);

    // Reset state, then LW
    step(6'h00, 1'b0, 1'b1);
    step(6'h21, 1'b0, 1'b0);
    settle();
    check("lw_instret", instret_a, 32'd1);
    check("lw_memread_gone", {mem_read[0], mem2reg[0]}, 2'b00 | {1'b0, 1'b0} | {op == 6'h21 ? 2'b11 : 2'b00});

    // Branches
    step(6'h23, 1'b1, 1'b0);
    step(6'h23, 1'b0, 1'b0);
    step(6'h24, 1'b1, 1'b0);
    step(6'h24, 1'b0, 1'b0);

    // CALL, RET, RET -> underflow
    step(6'h00, 1'b0, 1'b1);
    step(6'h25, 1'b0, 1'b0);
    settle(); check("call_sv", stack_valid[0], 1'b1);
    step(6'h26, 1'b0, 1'b0);
    settle(); check("ret_sv", stack_valid[0], 1'b0);
    step(6'h26, 1'b0, 1'b0);
    settle(); check("underflow_fault", fault_v[0], 2'b11);
    step(6'h20, 1'b0, 1'b0);

    // CALL, CALL -> overflow; outputs stay quiet afterwards
    step(6'h00, 1'b0, 1'b1);
    step(6'h25, 1'b0, 1'b0);
    step(6'h25, 1'b0, 1'b0);
    settle(); check("overflow_fault", fault_v[1], 2'b10);
    step(6'h21, 1'b0, 1'b0);
    step(6'h00, 1'b0, 1'b0);

    // Unknown opcode: trap on instance A, no-op retire on instance B
    step(6'h00, 1'b0, 1'b1);
    step(6'h30, 1'b0, 1'b0);
    settle();
    check("illegal_fault_a", fault_v[0], 2'b01);
    check("illegal_fault_b", fault_v[1], 2'b00);
    check("illegal_instret_b", instret_b, 4'd1);

    // HALT, reset mid-HALT, then ADDI
    step(6'h00, 1'b0, 1'b1);
    step(6'h3F, 1'b0, 1'b0);
    step(6'h20, 1'b0, 1'b0);
    settle(); check("halted_held", halted[0], 1'b1);
    step(6'h20, 1'b0, 1'b1);
    settle(); check("halt_reset_instret", instret_a, 32'd0);
    step(6'h20, 1'b0, 1'b0);
    settle(); check("addi_after_halt", instret_a, 32'd1);

    // Random opcode mix
    for (int n = 0; n < 1500; n++) begin
      int r = $urandom_range(0, 99);
      logic [5:0] o;
      if (r < 30)      o = {1'b0, 5'($urandom_range(0, 31))};
      else if (r < 45) o = 6'h20 + 6'($urandom_range(0, 2));
      else if (r < 60) o = 6'h23 + 6'($urandom_range(0, 1));
      else if (r < 73) o = 6'h25;
      else if (r < 86) o = 6'h26;
      else if (r < 95) o = 6'h27 + 6'($urandom_range(0, 23));
      else             o = 6'h3F;
      step(o, 1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
